ttt_move_ctrl: RTL and testbench

Registered, parametrised successor to the tic-tac-toe position decoder. It turns a position-switch value and an enable press into a single-cycle one-hot cell write pulse. It also tracks cell occupancy, cell ownership and whose turn it is, and rejects illegal moves. It sits between the debounced switch/button inputs and the per-cell storage and display logic.

---
 rtl/ttt_move_ctrl.sv | 113 +++++++++++
 tb/tb_ttt_move_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: turns a position switch and button press into a
// one-hot cell write pulse while tracking occupancy, ownership and turn order.
module ttt_move_ctrl #(
  parameter int CELLS = 9,
  parameter int SEL_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [SEL_W-1:0] POS_SW,
  input  logic             ENABLE,
  input  logic             CLEAR,
  output logic [CELLS-1:0] P_EN,
  output logic             MOVE_OK,
  output logic             MOVE_ERR,
  output logic [CELLS-1:0] OCC,
  output logic [CELLS-1:0] OWNER,
  output logic             PLAYER,
  output logic             FULL
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             en_q;
  logic [SEL_W-1:0] pos_q, pos_next;
  logic [CELLS-1:0] occ_next, owner_next, p_en_next;
  logic             player_next, ok_next, err_next;
  logic [CELLS-1:0] onehot;
  logic             legal;

  // Decode only real cells, so an out-of-range index yields an all-zero vector.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (pos_q == SEL_W'(i)) onehot[i] = 1'b1;
    end
  end

  assign legal = (|onehot) && !(|(onehot & OCC));
  assign FULL  = &OCC;

  always_comb begin
    state_next  = state;
    pos_next    = pos_q;
    occ_next    = OCC;
    owner_next  = OWNER;
    player_next = PLAYER;
    p_en_next   = '0;
    ok_next     = 1'b0;
    err_next    = 1'b0;
    if (CLEAR) begin
      occ_next    = '0;
      owner_next  = '0;
      player_next = 1'b0;
      state_next  = HOLD;
    end else begin
      case (state)
        IDLE: begin
          if (ENABLE && !en_q) begin
            pos_next   = POS_SW;
            state_next = EVAL;
          end
        end
        EVAL: begin
          if (legal) begin
            p_en_next   = onehot;
            ok_next     = 1'b1;
            occ_next    = OCC | onehot;
            owner_next  = (OWNER & ~onehot) | (PLAYER ? onehot : '0);
            player_next = !PLAYER;
          end else begin
            err_next = 1'b1;
          end
          state_next = HOLD;
        end
        HOLD: begin
          if (!ENABLE) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // en_q resets high so a button already held during reset is not a move.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      en_q     <= 1'b1;
      pos_q    <= '0;
      P_EN     <= '0;
      MOVE_OK  <= 1'b0;
      MOVE_ERR <= 1'b0;
      OCC      <= '0;
      OWNER    <= '0;
      PLAYER   <= 1'b0;
    end else begin
      state    <= state_next;
      en_q     <= ENABLE;
      pos_q    <= pos_next;
      P_EN     <= p_en_next;
      MOVE_OK  <= ok_next;
      MOVE_ERR <= err_next;
      OCC      <= occ_next;
      OWNER    <= owner_next;
      PLAYER   <= player_next;
    end
  end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Scoreboard bench for ttt_move_ctrl: stimulus pushes hand-computed expected
// pulses, a negedge monitor pops and compares whenever a pulse appears.
module tb_ttt_move_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] pos_sw;
  logic       enable;
  logic       clear;
  logic [8:0] p_en;
  logic       move_ok;
  logic       move_err;
  logic [8:0] occ;
  logic [8:0] owner;
  logic       player;
  logic       full;

  typedef struct {
    logic [8:0] p_en;
    logic       ok;
    logic       err;
    logic [8:0] occ;
    logic [8:0] owner;
    logic       player;
    int         cycle;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  ttt_move_ctrl #(.CELLS(9), .SEL_W(4)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .POS_SW(pos_sw),
    .ENABLE(enable),
    .CLEAR(clear),
    .P_EN(p_en),
    .MOVE_OK(move_ok),
    .MOVE_ERR(move_err),
    .OCC(occ),
    .OWNER(owner),
    .PLAYER(player),
    .FULL(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " p_en"}, 32'(p_en), 32'h0);
    check({tag, " move_ok"}, 32'(move_ok), 32'h0);
    check({tag, " move_err"}, 32'(move_err), 32'h0);
    check({tag, " occ"}, 32'(occ), 32'h0);
    check({tag, " owner"}, 32'(owner), 32'h0);
    check({tag, " player"}, 32'(player), 32'h0);
    check({tag, " full"}, 32'(full), 32'h0);
  endtask

  // Press at a negedge; the pulse is expected two rising edges later.
  task automatic press(input logic [3:0] pos, input int hold,
                       input logic [8:0] e_pen, input logic e_ok,
                       input logic [8:0] e_occ, input logic [8:0] e_owner,
                       input logic e_player);
    exp_t e;
    @(negedge clk);
    pos_sw = pos;
    enable = 1'b1;
    e.p_en = e_pen;
    e.ok = e_ok;
    e.err = !e_ok;
    e.occ = e_occ;
    e.owner = e_owner;
    e.player = e_player;
    e.cycle = cyc + 2;
    exp_q.push_back(e);
    @(negedge clk);
    pos_sw = pos ^ 4'b0101;
    repeat (hold - 1) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (move_ok || move_err || (p_en != 9'h0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected pulse: p_en=%0h ok=%0b err=%0b, expected none (cycle %0d)",
                 p_en, move_ok, move_err, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse cycle", 32'(cyc), 32'(e.cycle));
        check("p_en", 32'(p_en), 32'(e.p_en));
        check("move_ok", 32'(move_ok), 32'(e.ok));
        check("move_err", 32'(move_err), 32'(e.err));
        check("occ", 32'(occ), 32'(e.occ));
        check("owner", 32'(owner), 32'(e.owner));
        check("player", 32'(player), 32'(e.player));
        check("full", 32'(full), 32'(e.occ == 9'h1FF));
      end
    end
  end

  task automatic applyStimulus;
    logic [8:0] e_occ;
    // Reset with the button held; releasing reset must not count as a move.
    rst_n = 1'b0;
    enable = 1'b1;
    clear = 1'b0;
    pos_sw = 4'd4;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("held after reset");
    enable = 1'b0;
    repeat (2) @(negedge clk);

    press(4'd4, 10, 9'b000010000, 1'b1, 9'b000010000, 9'h0, 1'b1);
    press(4'd4, 2, 9'h0, 1'b0, 9'b000010000, 9'h0, 1'b1);
    press(4'd9, 2, 9'h0, 1'b0, 9'b000010000, 9'h0, 1'b1);
    press(4'd15, 1, 9'h0, 1'b0, 9'b000010000, 9'h0, 1'b1);

    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear occ", 32'(occ), 32'h0);
    check("clear player", 32'(player), 32'h0);
    repeat (2) @(negedge clk);

    // Fill the board in order; odd cells belong to player 1.
    for (int i = 0; i < 9; i++) begin
      e_occ = 9'((32'd1 << (i + 1)) - 1);
      press(4'(i), 2, 9'(32'd1 << i), 1'b1, e_occ, e_occ & 9'b010101010, (i % 2) == 0);
    end
    press(4'd3, 2, 9'h0, 1'b0, 9'h1FF, 9'b010101010, 1'b1);

    // CLEAR lands on the EVAL edge of a press on cell 2.
    @(negedge clk);
    pos_sw = 4'd2;
    enable = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear@eval occ", 32'(occ), 32'h0);
    check("clear@eval owner", 32'(owner), 32'h0);
    check("clear@eval player", 32'(player), 32'h0);
    check("clear@eval full", 32'(full), 32'h0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    press(4'd2, 2, 9'b000000100, 1'b1, 9'b000000100, 9'h0, 1'b1);
    press(4'd0, 2, 9'b000000001, 1'b1, 9'b000000101, 9'b000000001, 1'b0);
    press(4'd1, 2, 9'b000000010, 1'b1, 9'b000000111, 9'b000000001, 1'b1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid-game reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(4'd5, 2, 9'b000100000, 1'b1, 9'b000100000, 9'h0, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  task automatic checkOutput;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending pulses: %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus();
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
